int_sync_crossing_sink: RTL and testbench

INT_SYNC_CROSSING_SINK -- requirements
Module: int_sync_crossing_sink

---
 rtl/int_sync_crossing_sink.sv | 83 ++++++++
 tb/tb_int_sync_crossing_sink.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sync_crossing_sink.sv
// Sink side of an interrupt crossing: per-line synchronizer, optional deglitch
// filter, rising-edge strobe and sticky pending flag, all in the clock domain.
module int_sync_crossing_sink #(
  parameter int NUM_INT       = 1,
  parameter int SYNC_STAGES   = 3,
  parameter int FILTER_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_INT-1:0] auto_in_sync,
  output logic [NUM_INT-1:0] auto_out,
  output logic [NUM_INT-1:0] rise_pulse,
  output logic [NUM_INT-1:0] pending,
  input  logic [NUM_INT-1:0] pending_clr
);

  for (genvar i = 0; i < NUM_INT; i++) begin : g_line
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_q;
    logic                   line_out;
    logic                   auto_out_d;
    logic                   rise;
    logic                   pend_r;

    // Synchronizer chain: only stage 1 sees the asynchronous input
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync_chain <= '0;
      end else begin
        sync_chain <= {sync_chain[SYNC_STAGES-2:0], auto_in_sync[i]};
      end
    end

    assign sync_q = sync_chain[SYNC_STAGES-1];

    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign line_out = sync_q;
    end else begin : g_filt
      localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
      logic [CNT_W-1:0] cnt;
      logic             filt_q;

      // Deglitch: output follows sync_q only after FILTER_CYCLES straight mismatches
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt    <= '0;
          filt_q <= 1'b0;
        end else if (sync_q == filt_q) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
          filt_q <= sync_q;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign line_out = filt_q;
    end

    assign rise = line_out & ~auto_out_d;

    // Edge detect and sticky pending; a new rise beats a simultaneous clear
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        auto_out_d <= 1'b0;
        pend_r     <= 1'b0;
      end else begin
        auto_out_d <= line_out;
        if (rise) begin
          pend_r <= 1'b1;
        end else if (pending_clr[i]) begin
          pend_r <= 1'b0;
        end
      end
    end

    assign auto_out[i]   = line_out;
    assign rise_pulse[i] = rise;
    assign pending[i]    = pend_r;
  end

endmodule

// File: tb/tb_int_sync_crossing_sink.sv
// Bench for int_sync_crossing_sink: a 4-line unfiltered instance (a) and a
// 4-line SYNC_STAGES=2 / FILTER_CYCLES=4 instance (b) sharing clock and reset.
module tb_int_sync_crossing_sink;

  typedef struct packed {
    logic [3:0] din;
    logic [3:0] clr;
    logic [3:0] exp_out;
    logic [3:0] exp_rise;
    logic [3:0] exp_pend;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] in_a, clr_a, out_a, rise_a, pend_a;
  logic [3:0] in_b, clr_b, out_b, rise_b, pend_b;

  vec_t sb[$];
  vec_t v;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clock = ~clock;

  int_sync_crossing_sink #(.NUM_INT(4), .SYNC_STAGES(3), .FILTER_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .auto_in_sync(in_a), .auto_out(out_a),
    .rise_pulse(rise_a), .pending(pend_a), .pending_clr(clr_a)
  );

  int_sync_crossing_sink #(.NUM_INT(4), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset), .auto_in_sync(in_b), .auto_out(out_b),
    .rise_pulse(rise_b), .pending(pend_b), .pending_clr(clr_b)
  );

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({out_a, rise_a, pend_a, out_b, rise_b, pend_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_async: got %h, expected 000000", {out_a, rise_a, pend_a, out_b, rise_b, pend_b});
    end
    in_a = 4'hF;
    in_b = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      vectors++;
      if ({out_a, rise_a, pend_a, out_b, rise_b, pend_b} !== 24'h0) begin
        errors++;
        $display("FAIL reset_hold: got %h, expected 000000", {out_a, rise_a, pend_a, out_b, rise_b, pend_b});
      end
    end
    in_a = 4'h0;
    in_b = 4'h0;
    @(posedge clock); #1 reset = 1'b1;
  endtask

  task automatic test_latency;
    sb.push_back('{4'h1, 4'h0, 4'h0, 4'h0, 4'h0});
    sb.push_back('{4'h1, 4'h0, 4'h0, 4'h0, 4'h0});
    sb.push_back('{4'h1, 4'h0, 4'h1, 4'h1, 4'h0});
    sb.push_back('{4'h1, 4'h0, 4'h1, 4'h0, 4'h1});
    sb.push_back('{4'h1, 4'h0, 4'h1, 4'h0, 4'h1});
    for (int k = 1; sb.size() > 0; k++) begin
      v = sb.pop_front();
      in_a = v.din; clr_a = v.clr;
      @(posedge clock); #1;
      vectors++;
      if ({out_a, rise_a, pend_a} !== {v.exp_out, v.exp_rise, v.exp_pend}) begin
        errors++;
        $display("FAIL latency edge %0d: out/rise/pend=%h/%h/%h, expected %h/%h/%h",
                 k, out_a, rise_a, pend_a, v.exp_out, v.exp_rise, v.exp_pend);
      end
    end
  endtask

  task automatic test_falling_edge;
    sb.push_back('{4'h0, 4'h0, 4'h1, 4'h0, 4'h1});
    sb.push_back('{4'h0, 4'h0, 4'h1, 4'h0, 4'h1});
    sb.push_back('{4'h0, 4'h0, 4'h0, 4'h0, 4'h1});
    sb.push_back('{4'h0, 4'h0, 4'h0, 4'h0, 4'h1});
    for (int k = 1; sb.size() > 0; k++) begin
      v = sb.pop_front();
      in_a = v.din; clr_a = v.clr;
      @(posedge clock); #1;
      vectors++;
      if ({out_a, rise_a, pend_a} !== {v.exp_out, v.exp_rise, v.exp_pend}) begin
        errors++;
        $display("FAIL falling_edge edge %0d: out/rise/pend=%h/%h/%h, expected %h/%h/%h",
                 k, out_a, rise_a, pend_a, v.exp_out, v.exp_rise, v.exp_pend);
      end
    end
  endtask

  task automatic test_set_wins;
    sb.push_back('{4'h1, 4'h1, 4'h0, 4'h0, 4'h0});
    sb.push_back('{4'h1, 4'h1, 4'h0, 4'h0, 4'h0});
    sb.push_back('{4'h1, 4'h1, 4'h1, 4'h1, 4'h0});
    sb.push_back('{4'h1, 4'h1, 4'h1, 4'h0, 4'h1});
    sb.push_back('{4'h1, 4'h0, 4'h1, 4'h0, 4'h1});
    sb.push_back('{4'h1, 4'h1, 4'h1, 4'h0, 4'h0});
    sb.push_back('{4'h1, 4'h0, 4'h1, 4'h0, 4'h0});
    for (int k = 1; sb.size() > 0; k++) begin
      v = sb.pop_front();
      in_a = v.din; clr_a = v.clr;
      @(posedge clock); #1;
      vectors++;
      if ({out_a, rise_a, pend_a} !== {v.exp_out, v.exp_rise, v.exp_pend}) begin
        errors++;
        $display("FAIL set_wins edge %0d: out/rise/pend=%h/%h/%h, expected %h/%h/%h",
                 k, out_a, rise_a, pend_a, v.exp_out, v.exp_rise, v.exp_pend);
      end
    end
    clr_a = 4'h0;
  endtask

  task automatic test_independence;
    sb.push_back('{4'h9, 4'h0, 4'h1, 4'h0, 4'h0});
    sb.push_back('{4'h9, 4'h0, 4'h1, 4'h0, 4'h0});
    sb.push_back('{4'h9, 4'h0, 4'h9, 4'h8, 4'h0});
    sb.push_back('{4'h9, 4'h0, 4'h9, 4'h0, 4'h8});
    sb.push_back('{4'hD, 4'h0, 4'h9, 4'h0, 4'h8});
    sb.push_back('{4'hD, 4'h0, 4'h9, 4'h0, 4'h8});
    sb.push_back('{4'hD, 4'h0, 4'hD, 4'h4, 4'h8});
    sb.push_back('{4'hD, 4'h0, 4'hD, 4'h0, 4'hC});
    sb.push_back('{4'h9, 4'h0, 4'hD, 4'h0, 4'hC});
    sb.push_back('{4'h9, 4'h0, 4'hD, 4'h0, 4'hC});
    sb.push_back('{4'h9, 4'h0, 4'h9, 4'h0, 4'hC});
    sb.push_back('{4'hD, 4'h0, 4'h9, 4'h0, 4'hC});
    sb.push_back('{4'hD, 4'h0, 4'h9, 4'h0, 4'hC});
    sb.push_back('{4'hD, 4'h0, 4'hD, 4'h4, 4'hC});
    sb.push_back('{4'hD, 4'h0, 4'hD, 4'h0, 4'hC});
    sb.push_back('{4'hD, 4'h4, 4'hD, 4'h0, 4'h8});
    sb.push_back('{4'hD, 4'h0, 4'hD, 4'h0, 4'h8});
    for (int k = 1; sb.size() > 0; k++) begin
      v = sb.pop_front();
      in_a = v.din; clr_a = v.clr;
      @(posedge clock); #1;
      vectors++;
      if ({out_a, rise_a, pend_a} !== {v.exp_out, v.exp_rise, v.exp_pend}) begin
        errors++;
        $display("FAIL independence edge %0d: out/rise/pend=%h/%h/%h, expected %h/%h/%h",
                 k, out_a, rise_a, pend_a, v.exp_out, v.exp_rise, v.exp_pend);
      end
    end
  endtask

  task automatic test_reset_mid;
    sb.push_back('{4'hF, 4'h0, 4'hD, 4'h0, 4'h8});
    sb.push_back('{4'hF, 4'h0, 4'hD, 4'h0, 4'h8});
    for (int k = 1; sb.size() > 0; k++) begin
      v = sb.pop_front();
      in_a = v.din; clr_a = v.clr;
      @(posedge clock); #1;
      vectors++;
      if ({out_a, rise_a, pend_a} !== {v.exp_out, v.exp_rise, v.exp_pend}) begin
        errors++;
        $display("FAIL reset_mid_pre edge %0d: out/rise/pend=%h/%h/%h, expected %h/%h/%h",
                 k, out_a, rise_a, pend_a, v.exp_out, v.exp_rise, v.exp_pend);
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({out_a, rise_a, pend_a} !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid_entry: out/rise/pend=%h/%h/%h, expected 0/0/0", out_a, rise_a, pend_a);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      vectors++;
      if ({out_a, rise_a, pend_a} !== 12'h0) begin
        errors++;
        $display("FAIL reset_mid_hold: out/rise/pend=%h/%h/%h, expected 0/0/0", out_a, rise_a, pend_a);
      end
    end
    reset = 1'b1;
    sb.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 4'h0});
    sb.push_back('{4'hF, 4'h0, 4'h0, 4'h0, 4'h0});
    sb.push_back('{4'hF, 4'h0, 4'hF, 4'hF, 4'h0});
    sb.push_back('{4'hF, 4'h0, 4'hF, 4'h0, 4'hF});
    sb.push_back('{4'hF, 4'h0, 4'hF, 4'h0, 4'hF});
    for (int k = 1; sb.size() > 0; k++) begin
      v = sb.pop_front();
      in_a = v.din; clr_a = v.clr;
      @(posedge clock); #1;
      vectors++;
      if ({out_a, rise_a, pend_a} !== {v.exp_out, v.exp_rise, v.exp_pend}) begin
        errors++;
        $display("FAIL reset_mid_release edge %0d: out/rise/pend=%h/%h/%h, expected %h/%h/%h",
                 k, out_a, rise_a, pend_a, v.exp_out, v.exp_rise, v.exp_pend);
      end
    end
  endtask

  task automatic test_glitch;
    for (int k = 0; k < 3; k++) sb.push_back('{4'h1, 4'h0, 4'h0, 4'h0, 4'h0});
    for (int k = 0; k < 5; k++) sb.push_back('{4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
    for (int k = 1; sb.size() > 0; k++) begin
      v = sb.pop_front();
      in_b = v.din; clr_b = v.clr;
      @(posedge clock); #1;
      vectors++;
      if ({out_b, rise_b, pend_b} !== {v.exp_out, v.exp_rise, v.exp_pend}) begin
        errors++;
        $display("FAIL glitch edge %0d: out/rise/pend=%h/%h/%h, expected %h/%h/%h",
                 k, out_b, rise_b, pend_b, v.exp_out, v.exp_rise, v.exp_pend);
      end
    end
  endtask

  task automatic test_filter;
    for (int k = 0; k < 5; k++) sb.push_back('{4'h1, 4'h0, 4'h0, 4'h0, 4'h0});
    sb.push_back('{4'h1, 4'h0, 4'h1, 4'h1, 4'h0});
    sb.push_back('{4'h1, 4'h0, 4'h1, 4'h0, 4'h1});
    sb.push_back('{4'h1, 4'h0, 4'h1, 4'h0, 4'h1});
    for (int k = 0; k < 5; k++) sb.push_back('{4'h0, 4'h0, 4'h1, 4'h0, 4'h1});
    sb.push_back('{4'h0, 4'h0, 4'h0, 4'h0, 4'h1});
    sb.push_back('{4'h0, 4'h0, 4'h0, 4'h0, 4'h1});
    for (int k = 1; sb.size() > 0; k++) begin
      v = sb.pop_front();
      in_b = v.din; clr_b = v.clr;
      @(posedge clock); #1;
      vectors++;
      if ({out_b, rise_b, pend_b} !== {v.exp_out, v.exp_rise, v.exp_pend}) begin
        errors++;
        $display("FAIL filter edge %0d: out/rise/pend=%h/%h/%h, expected %h/%h/%h",
                 k, out_b, rise_b, pend_b, v.exp_out, v.exp_rise, v.exp_pend);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_a  = 4'h0;
    clr_a = 4'h0;
    in_b  = 4'h0;
    clr_b = 4'h0;
    test_reset;
    test_latency;
    test_falling_edge;
    test_set_wins;
    test_independence;
    test_reset_mid;
    test_glitch;
    test_filter;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
